vga_buffer_swap_ctrl: RTL

VGA_BUFFER_SWAP_CTRL -- requirements
Module: vga_buffer_swap_ctrl

---
 rtl/vga_buffer_swap_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/vga_buffer_swap_ctrl.sv
// vga_buffer_swap_ctrl
// Drives a pixel-buffer DMA control slave to swap front/back buffers:
// write the new back-buffer address, trigger the swap, then poll the status
// register until the swap bit clears. Requests arriving while busy are held in
// a one-deep pending slot (latest wins) and run right after the current swap.
//
// Optional feature macro: VGA_SWAP_TIMEOUT_EN
//   When defined, polling is bounded by TIMEOUT_CYCLES and a stuck swap ends
//   in ERR with a one-cycle swap_timeout pulse. When undefined, polling runs
//   indefinitely and swap_timeout is tied low.
//
// Handshake: swap_req is a level sampled on every rising edge; each edge that
// sees it high is one request. swap_busy is high from the cycle after the
// request is accepted through the DONE/ERR cycle. The bus side is a fixed
// latency-1 read slave without waitrequest: each strobe lasts exactly one
// cycle, and read data is taken in the cycle after m_read.
module vga_buffer_swap_ctrl #(
  parameter int POLL_GAP       = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        sys_clk_clk,
  input  logic        sys_reset_reset,
  input  logic        swap_req,
  input  logic [31:0] swap_addr,
  output logic        swap_busy,
  output logic        swap_done,
  output logic        swap_timeout,
  output logic [15:0] swap_count,
  output logic [1:0]  m_address,
  output logic [3:0]  m_byteenable,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_BACK  = 3'd1,
    WR_SWAP  = 3'd2,
    POLL_RD  = 3'd3,
    POLL_CHK = 3'd4,
    GAP      = 3'd5,
    DONE     = 3'd6,
    ERR      = 3'd7
  } state_t;

  localparam logic [15:0] GAP_LAST = 16'((POLL_GAP > 0) ? (POLL_GAP - 1) : 0);
  localparam logic [31:0] TO_LAST  = 32'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  state_t      state;
  state_t      state_n;
  logic [31:0] cur_addr;
  logic [31:0] pend_addr;
  logic        pend_valid;
  logic [15:0] gap_cnt;
  logic        swap_busy_bit;
  logic        timeout_hit;
  logic        finishing;
  logic        restart;

  // DONE and ERR both close out a swap; a request seen in that same cycle
  // counts as pending and is newer than anything already stored.
  assign finishing     = (state == DONE) || (state == ERR);
  assign restart       = finishing && (swap_req || pend_valid);
  assign swap_busy_bit = m_readdata[0];
  assign dbg_state     = state;

`ifdef VGA_SWAP_TIMEOUT_EN
  logic [31:0] to_cnt;

  // Poll-phase cycle counter, restarted each time a swap is triggered.
  always_ff @(posedge sys_clk_clk or posedge sys_reset_reset) begin
    if (sys_reset_reset) begin
      to_cnt <= '0;
    end else if (state == WR_SWAP) begin
      to_cnt <= '0;
    end else if ((state == POLL_RD) || (state == POLL_CHK) || (state == GAP)) begin
      to_cnt <= to_cnt + 32'd1;
    end
  end

  assign timeout_hit = (to_cnt == TO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // Upper status bits carry nothing for us; TO_LAST only matters with the timeout.
  logic unused_inputs;
  assign unused_inputs = ^{m_readdata[31:1], TO_LAST};

  // State register.
  always_ff @(posedge sys_clk_clk or posedge sys_reset_reset) begin
    if (sys_reset_reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic; a clean status read takes priority over a timeout.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (swap_req) state_n = WR_BACK;
      WR_BACK:  state_n = WR_SWAP;
      WR_SWAP:  state_n = POLL_RD;
      POLL_RD:  state_n = timeout_hit ? ERR : POLL_CHK;
      POLL_CHK: begin
        if (!swap_busy_bit)    state_n = DONE;
        else if (timeout_hit)  state_n = ERR;
        else if (POLL_GAP == 0) state_n = POLL_RD;
        else                   state_n = GAP;
      end
      GAP: begin
        if (timeout_hit)             state_n = ERR;
        else if (gap_cnt == GAP_LAST) state_n = POLL_RD;
      end
      DONE, ERR: state_n = restart ? WR_BACK : IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // Moore outputs decoded from state so reset removes strobes at once.
  always_comb begin
    swap_busy    = (state != IDLE);
    swap_done    = (state == DONE);
    swap_timeout = (state == ERR);
    m_address    = 2'd0;
    m_byteenable = 4'h0;
    m_read       = 1'b0;
    m_write      = 1'b0;
    m_writedata  = 32'd0;
    case (state)
      WR_BACK: begin
        m_write      = 1'b1;
        m_address    = 2'd1;
        m_byteenable = 4'hF;
        m_writedata  = cur_addr;
      end
      WR_SWAP: begin
        m_write      = 1'b1;
        m_address    = 2'd0;
        m_byteenable = 4'hF;
      end
      POLL_RD: begin
        m_read       = 1'b1;
        m_address    = 2'd3;
        m_byteenable = 4'hF;
      end
      default: ;
    endcase
  end

  // Address latching, pending slot, gap timer and success counter.
  always_ff @(posedge sys_clk_clk or posedge sys_reset_reset) begin
    if (sys_reset_reset) begin
      cur_addr   <= '0;
      pend_addr  <= '0;
      pend_valid <= 1'b0;
      gap_cnt    <= '0;
      swap_count <= '0;
    end else begin
      if ((state == IDLE) && swap_req) begin
        cur_addr <= swap_addr;
      end else if (restart) begin
        cur_addr <= swap_req ? swap_addr : pend_addr;
      end

      if (finishing) begin
        pend_valid <= 1'b0;
      end else if ((state != IDLE) && swap_req) begin
        pend_addr  <= swap_addr;
        pend_valid <= 1'b1;
      end

      gap_cnt <= (state == GAP) ? gap_cnt + 16'd1 : 16'd0;

      if (state == DONE) begin
        swap_count <= swap_count + 16'd1;
      end
    end
  end

endmodule
